via_bus_arbiter: RTL and testbench

- Shares the single register port of the on-board 6522 VIA between two requesters: the 6502 CPU bus bridge (m0) and an auxiliary engine (m1), such as the keyboard/printer sequencer.
- Serialises register transactions and drives exactly one chip-select cycle per transaction, because VIA reads have side effects (a T1C_L read clears IFR[6], a T2C_L read clears IFR[5]).
- Captures VIA read data and returns it with a single-cycle acknowledge.
- Provides round-robin or fixed-priority arbitration, plus a bounded lock for multi-register sequences such as a T1 low-then-high load.

---
 rtl/via_arb_pkg.sv | 32 +++
 rtl/via_arb_pick.sv | 39 +++
 rtl/via_bus_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_via_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/via_arb_pkg.sv
// Shared definitions for the VIA register-port arbiter: the sequencer state
// encoding and the 6522 register index map used by both requesters.
package via_arb_pkg;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_e;

    // 6522 VIA register indices (RS3..RS0).
    localparam logic [3:0] ORB    = 4'h0;
    localparam logic [3:0] ORA    = 4'h1;
    localparam logic [3:0] DDRB   = 4'h2;
    localparam logic [3:0] DDRA   = 4'h3;
    localparam logic [3:0] T1C_L  = 4'h4;
    localparam logic [3:0] T1C_H  = 4'h5;
    localparam logic [3:0] T1L_L  = 4'h6;
    localparam logic [3:0] T1L_H  = 4'h7;
    localparam logic [3:0] T2C_L  = 4'h8;
    localparam logic [3:0] T2C_H  = 4'h9;
    localparam logic [3:0] SR     = 4'hA;
    localparam logic [3:0] ACR    = 4'hB;
    localparam logic [3:0] PCR    = 4'hC;
    localparam logic [3:0] IFR    = 4'hD;
    localparam logic [3:0] IER    = 4'hE;
    localparam logic [3:0] ORA_NH = 4'hF;

endpackage

// File: rtl/via_arb_pick.sv
// Combinational winner select for the VIA arbiter. A held lock beats
// everything, a lone request wins outright, and contention is settled by a
// pending forced release, then round-robin or fixed m0 priority.
module via_arb_pick (
    input  logic [1:0] req_i,
    input  logic       rr_i,
    input  logic       locked_i,
    input  logic       owner_i,
    input  logic       last_owner_i,
    input  logic       forced_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    // Priority chain for the grant index; valid whenever anyone requests.
    always_comb begin
        // NOTE: every output gets a value before any branch, so no path through
        // the block leaves a signal unassigned and no latch is inferred.
        grant_valid_o = |req_i;
        grant_idx_o   = 1'b0;
        if (locked_i && req_i[owner_i]) begin
            grant_idx_o = owner_i;
        end else if (req_i == 2'b10) begin
            grant_idx_o = 1'b1;
        end else if (req_i == 2'b01) begin
            grant_idx_o = 1'b0;
        end else if (req_i == 2'b11) begin
            if (forced_i) begin
                // Owner just hit the lock ceiling: the other side goes next.
                grant_idx_o = ~owner_i;
            end else if (rr_i) begin
                grant_idx_o = ~last_owner_i;
            end else begin
                grant_idx_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/via_bus_arbiter.sv
// Two-master arbiter for the single 6522 VIA register port. Each granted
// transaction produces exactly one chip-select cycle (VIA reads have side
// effects), read data is captured into the owner's rdata register, and the
// owner gets a one-cycle ack. Masters may lock the port for short
// multi-register sequences, bounded by LOCK_MAX consecutive grants.
module via_bus_arbiter
    import via_arb_pkg::*;
#(
    parameter int RR         = 1,
    parameter int GAP_CYCLES = 0,
    parameter int LOCK_MAX   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m0_lock,
    input  logic       m0_we,
    input  logic [3:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_lock,
    input  logic       m1_we,
    input  logic [3:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       via_cs,
    output logic       via_rw,
    output logic [3:0] via_addr,
    output logic [7:0] via_wdata,
    input  logic [7:0] via_rdata,
    output logic       busy,
    output logic       owner
);

    localparam logic [3:0] GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [8:0] LOCK_LIM  = 9'(LOCK_MAX);

    state_e     state_q,      state_d;
    logic       cs_q,         cs_d;
    logic       rw_q,         rw_d;
    logic [3:0] addr_q,       addr_d;
    logic [7:0] wdata_q,      wdata_d;
    logic [1:0] ack_q,        ack_d;
    logic [7:0] rdata0_q,     rdata0_d;
    logic [7:0] rdata1_q,     rdata1_d;
    logic       busy_q,       busy_d;
    logic       owner_q,      owner_d;
    logic       last_owner_q, last_owner_d;
    logic       locked_q,     locked_d;
    logic [7:0] lock_cnt_q,   lock_cnt_d;
    logic       forced_q,     forced_d;
    logic       we_q,         we_d;
    logic [3:0] gap_cnt_q,    gap_cnt_d;

    logic [1:0] req;
    logic       grant_valid;
    logic       grant_idx;
    logic       owner_lock;

    assign req        = {m1_req, m0_req};
    assign owner_lock = owner_q ? m1_lock : m0_lock;

    via_arb_pick u_pick (
        .req_i         (req),
        .rr_i          (RR != 0),
        .locked_i      (locked_q),
        .owner_i       (owner_q),
        .last_owner_i  (last_owner_q),
        .forced_i      (forced_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // Sequencer next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        cs_d         = 1'b0;
        rw_d         = 1'b1;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ack_d        = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        locked_d     = locked_q;
        lock_cnt_d   = lock_cnt_q;
        forced_d     = forced_q;
        we_d         = we_q;
        gap_cnt_d    = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d      = ISSUE;
                    cs_d         = 1'b1;
                    we_d         = grant_idx ? m1_we    : m0_we;
                    rw_d         = ~(grant_idx ? m1_we  : m0_we);
                    addr_d       = grant_idx ? m1_addr  : m0_addr;
                    wdata_d      = grant_idx ? m1_wdata : m0_wdata;
                    owner_d      = grant_idx;
                    last_owner_d = grant_idx;
                    // A locked owner that went quiet loses the lock to the other side.
                    if (locked_q && (grant_idx != owner_q)) begin
                        locked_d   = 1'b0;
                        lock_cnt_d = 8'd0;
                    end
                    // The forced-release preference lasts until it decides a
                    // contention or the other master gets in anyway.
                    if (forced_q && ((req == 2'b11) || (grant_idx != owner_q))) begin
                        forced_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!we_q) begin
                    if (owner_q) rdata1_d = via_rdata;
                    else         rdata0_d = via_rdata;
                end
                ack_d[owner_q] = 1'b1;
                state_d        = DONE;
            end
            DONE: begin
                if (owner_lock) begin
                    if (({1'b0, lock_cnt_q} + 9'd1) >= LOCK_LIM) begin
                        locked_d   = 1'b0;
                        lock_cnt_d = 8'd0;
                        forced_d   = 1'b1;
                    end else begin
                        locked_d   = 1'b1;
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end else begin
                    locked_d   = 1'b0;
                    lock_cnt_d = 8'd0;
                end
                gap_cnt_d = 4'd0;
                state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; synchronous reset aborts any transaction.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (reset) begin
            state_q      <= IDLE;
            cs_q         <= 1'b0;
            rw_q         <= 1'b1;
            addr_q       <= 4'd0;
            wdata_q      <= 8'd0;
            ack_q        <= 2'b00;
            rdata0_q     <= 8'd0;
            rdata1_q     <= 8'd0;
            busy_q       <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            locked_q     <= 1'b0;
            lock_cnt_q   <= 8'd0;
            forced_q     <= 1'b0;
            we_q         <= 1'b0;
            gap_cnt_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            cs_q         <= cs_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            locked_q     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
            forced_q     <= forced_d;
            we_q         <= we_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign via_cs    = cs_q;
    assign via_rw    = rw_q;
    assign via_addr  = addr_q;
    assign via_wdata = wdata_q;
    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_via_bus_arbiter.sv
// Directed bench for via_bus_arbiter. Instance A (RR=1, no gap, LOCK_MAX=8)
// talks to a small VIA model; instance B (RR=0, GAP_CYCLES=1, LOCK_MAX=2)
// shares the same requester inputs and sees a constant read value.
module tb_via_bus_arbiter;
    import via_arb_pkg::*;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       lock;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req, lock, we;
    logic [3:0] addr  [2];
    logic [7:0] wdata [2];

    logic [1:0] a_ack, b_ack;
    logic [7:0] a_rdata [2];
    logic [7:0] b_rdata [2];
    logic       a_cs, a_rw, a_busy, a_owner, b_cs, b_rw, b_busy, b_owner;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata, a_rdin, b_rdin;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    via_bus_arbiter #(.RR(1), .GAP_CYCLES(0), .LOCK_MAX(8)) u_a (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]),
        .m0_wdata(wdata[0]), .m0_ack(a_ack[0]), .m0_rdata(a_rdata[0]),
        .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]),
        .m1_wdata(wdata[1]), .m1_ack(a_ack[1]), .m1_rdata(a_rdata[1]),
        .via_cs(a_cs), .via_rw(a_rw), .via_addr(a_addr), .via_wdata(a_wdata),
        .via_rdata(a_rdin), .busy(a_busy), .owner(a_owner)
    );

    via_bus_arbiter #(.RR(0), .GAP_CYCLES(1), .LOCK_MAX(2)) u_b (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]),
        .m0_wdata(wdata[0]), .m0_ack(b_ack[0]), .m0_rdata(b_rdata[0]),
        .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]),
        .m1_wdata(wdata[1]), .m1_ack(b_ack[1]), .m1_rdata(b_rdata[1]),
        .via_cs(b_cs), .via_rw(b_rw), .via_addr(b_addr), .via_wdata(b_wdata),
        .via_rdata(b_rdin), .busy(b_busy), .owner(b_owner)
    );

    assign b_rdin = 8'h3C;

    // Minimal 6522 model for instance A: IFR, T1 latch/counter, read side effects.
    logic [7:0]  ifr, t1_lo_latch, rd_q;
    logic [15:0] t1;
    int          cs_cycles = 0;
    int          t1cl_reads = 0;

    always @(posedge clk) begin
        if (reset) begin
            ifr         <= 8'hC0;
            t1          <= 16'h0000;
            t1_lo_latch <= 8'h00;
            rd_q        <= 8'h00;
        end else if (a_cs) begin
            cs_cycles <= cs_cycles + 1;
            if (!a_rw) begin
                case (a_addr)
                    T1C_L, T1L_L: t1_lo_latch <= a_wdata;
                    T1C_H: begin
                        t1     <= {a_wdata, t1_lo_latch};
                        ifr[6] <= 1'b0;
                    end
                    default: ;
                endcase
            end else begin
                case (a_addr)
                    IFR:   rd_q <= ifr;
                    T1C_L: begin
                        rd_q       <= t1[7:0];
                        ifr[6]     <= 1'b0;
                        t1cl_reads <= t1cl_reads + 1;
                    end
                    T1C_H: rd_q <= t1[15:8];
                    default: rd_q <= 8'h11;
                endcase
            end
        end
    end

    assign a_rdin = rd_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = 2'b00; lock = 2'b00; we = 2'b00;
        addr[0] = 4'd0; addr[1] = 4'd0; wdata[0] = 8'd0; wdata[1] = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // One uncontended transaction on instance A with cycle-exact checks.
    task automatic single(input int m, input logic w, input logic [3:0] ad,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        int cs0;
        @(negedge clk);
        cs0 = cs_cycles;
        check("t0_cs", a_cs, 0);
        req[m] = 1'b1; we[m] = w; addr[m] = ad; wdata[m] = wd; lock[m] = 1'b0;
        @(negedge clk);
        check("t1_cs", a_cs, 1);
        check("t1_rw", a_rw, !w);
        check("t1_addr", a_addr, ad);
        if (w) check("t1_wdata", a_wdata, wd);
        check("t1_owner", a_owner, m);
        check("t1_busy", a_busy, 1);
        @(negedge clk);
        check("t2_cs", a_cs, 0);
        check("t2_rw", a_rw, 1);
        check("t2_ack", a_ack, 0);
        @(negedge clk);
        check("t3_ack", a_ack[m], 1);
        check("t3_ack_other", a_ack[1-m], 0);
        check("t3_rdata", a_rdata[m], exp_rd);
        @(negedge clk);
        req[m] = 1'b0;
        check("t4_ack", a_ack, 0);
        check("cs_pulses", cs_cycles - cs0, 1);
    endtask

    txn_t q0[$];
    txn_t q1[$];
    int   ack_m[$];
    int   ack_t[$];

    task automatic drive_reqs();
        if (q0.size() > 0) begin
            req[0] = 1'b1; we[0] = q0[0].we; addr[0] = q0[0].addr;
            wdata[0] = q0[0].wdata; lock[0] = q0[0].lock;
        end else begin
            req[0] = 1'b0; lock[0] = 1'b0;
        end
        if (q1.size() > 0) begin
            req[1] = 1'b1; we[1] = q1[0].we; addr[1] = q1[0].addr;
            wdata[1] = q1[0].wdata; lock[1] = q1[0].lock;
        end else begin
            req[1] = 1'b0; lock[1] = 1'b0;
        end
    endtask

    // Requesters replay their queues; each ack advances that master's queue,
    // and new fields are presented only after the ack cycle has ended.
    task automatic run_seq(input bit use_b, input int n_acks, input int budget);
        int         cyc;
        logic [1:0] ackv;
        cyc = 0;
        ack_m.delete();
        ack_t.delete();
        while (ack_m.size() < n_acks && cyc < budget) begin
            @(posedge clk);
            #1 drive_reqs();
            @(negedge clk);
            cyc++;
            ackv = use_b ? b_ack : a_ack;
            if (ackv[0]) begin ack_m.push_back(0); ack_t.push_back(cyc); void'(q0.pop_front()); end
            if (ackv[1]) begin ack_m.push_back(1); ack_t.push_back(cyc); void'(q1.pop_front()); end
        end
        check("seq_acks_seen", ack_m.size(), n_acks);
        q0.delete();
        q1.delete();
        req = 2'b00;
        lock = 2'b00;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_order[6];
        int t1cl0;

        // Reset values.
        do_reset();
        @(negedge clk);
        check("rst_cs", a_cs, 0);
        check("rst_rw", a_rw, 1);
        check("rst_addr", a_addr, 0);
        check("rst_wdata", a_wdata, 0);
        check("rst_ack", a_ack, 0);
        check("rst_rdata0", a_rdata[0], 0);
        check("rst_rdata1", a_rdata[1], 0);
        check("rst_busy", a_busy, 0);
        check("rst_owner", a_owner, 0);

        // m0 writes ACR; m0_rdata stays at its reset value.
        single(0, 1'b1, ACR, 8'h40, 8'h00);
        @(negedge clk);
        check("idle_addr_hold", a_addr, ACR);
        check("idle_wdata_hold", a_wdata, 8'h40);

        // m1 reads IFR, then T1C_L (clears IFR[6] once), then IFR again.
        t1cl0 = t1cl_reads;
        single(1, 1'b0, IFR, 8'h00, 8'hC0);
        single(1, 1'b0, T1C_L, 8'h00, 8'h00);
        single(1, 1'b0, IFR, 8'h00, 8'h80);
        check("t1cl_read_once", t1cl_reads - t1cl0, 1);
        check("m0_rdata_untouched", a_rdata[0], 8'h00);

        // Round-robin with both masters requesting continuously.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{we: 1'b1, addr: ORB, wdata: 8'(i), lock: 1'b0});
            q1.push_back('{we: 1'b1, addr: ORA, wdata: 8'(i), lock: 1'b0});
        end
        run_seq(1'b0, 4, 40);
        if (ack_m.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), ack_m[i], i % 2);
            check("rr_first_ack", ack_t[0], 4);
            for (int i = 1; i < 4; i++) check($sformatf("rr_space%0d", i), ack_t[i] - ack_t[i-1], 4);
        end

        // Fixed priority: m0 keeps winning while it requests; gap adds a cycle.
        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back('{we: 1'b1, addr: ORB, wdata: 8'(i), lock: 1'b0});
        q1.push_back('{we: 1'b1, addr: ORA, wdata: 8'h77, lock: 1'b0});
        run_seq(1'b1, 5, 60);
        if (ack_m.size() >= 5) begin
            exp_order = '{0, 0, 0, 0, 1, 0};
            for (int i = 0; i < 5; i++) check($sformatf("fp_order%0d", i), ack_m[i], exp_order[i]);
            check("fp_gap_space", ack_t[1] - ack_t[0], 5);
        end

        // Locked T1 load by m0 while m1 contends.
        do_reset();
        q0.push_back('{we: 1'b1, addr: T1C_L, wdata: 8'h34, lock: 1'b1});
        q0.push_back('{we: 1'b1, addr: T1C_H, wdata: 8'h12, lock: 1'b0});
        q1.push_back('{we: 1'b1, addr: DDRA, wdata: 8'hFF, lock: 1'b0});
        run_seq(1'b0, 3, 40);
        if (ack_m.size() >= 3) begin
            check("lock_order0", ack_m[0], 0);
            check("lock_order1", ack_m[1], 0);
            check("lock_order2", ack_m[2], 1);
        end
        check("t1_loaded", t1, 16'h1234);

        // Lock ceiling of 2 on instance B: forced release lets m1 in.
        do_reset();
        for (int i = 0; i < 5; i++) q0.push_back('{we: 1'b1, addr: ORB, wdata: 8'(i), lock: 1'b1});
        q1.push_back('{we: 1'b1, addr: ORA, wdata: 8'h55, lock: 1'b0});
        run_seq(1'b1, 6, 80);
        if (ack_m.size() >= 6) begin
            exp_order = '{0, 0, 1, 0, 0, 0};
            for (int i = 0; i < 6; i++) check($sformatf("lockmax_order%0d", i), ack_m[i], exp_order[i]);
        end

        // Reset while an m1 read sits in WAIT.
        do_reset();
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = IFR;
        @(negedge clk);
        check("abort_issue_cs", a_cs, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ack", a_ack, 0);
        check("abort_cs", a_cs, 0);
        check("abort_rw", a_rw, 1);
        check("abort_addr", a_addr, 0);
        check("abort_busy", a_busy, 0);
        check("abort_owner", a_owner, 0);
        check("abort_rdata1", a_rdata[1], 0);
        reset = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        check("abort_no_late_ack", a_ack, 0);
        single(0, 1'b0, IFR, 8'h00, 8'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
